// File: rtl/fwnoc_pkg.sv
// Shared fwnoc definitions: header field layout, packet size decode and the
// ingress/egress state encoding.
package fwnoc_pkg;

    localparam int SZ_LSB    = 0;
    localparam int SZ_MSB    = 3;
    localparam int PORT_LSB  = 4;
    localparam int PORT_MSB  = 5;
    localparam int SZ_W      = SZ_MSB - SZ_LSB + 1;
    localparam int PORT_W    = PORT_MSB - PORT_LSB + 1;
    localparam int NUM_PORTS = 1 << PORT_W;
    localparam int PAY_W     = 5;

    localparam logic [SZ_W-1:0] SZ_CODE_0  = 4'd0;
    localparam logic [SZ_W-1:0] SZ_CODE_1  = 4'd1;
    localparam logic [SZ_W-1:0] SZ_CODE_2  = 4'd2;
    localparam logic [SZ_W-1:0] SZ_CODE_4  = 4'd3;
    localparam logic [SZ_W-1:0] SZ_CODE_8  = 4'd4;
    localparam logic [SZ_W-1:0] SZ_CODE_16 = 4'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FWD  = 1'b1
    } state_t;

    // Payload words following the header; unsupported codes become header-only.
    function automatic logic [PAY_W-1:0] size_decode(input logic [SZ_W-1:0] code);
        case (code)
            SZ_CODE_0:  return 5'd0;
            SZ_CODE_1:  return 5'd1;
            SZ_CODE_2:  return 5'd2;
            SZ_CODE_4:  return 5'd4;
            SZ_CODE_8:  return 5'd8;
            SZ_CODE_16: return 5'd16;
            default:    return 5'd0;
        endcase
    endfunction

    function automatic logic size_code_bad(input logic [SZ_W-1:0] code);
        return code > SZ_CODE_16;
    endfunction

endpackage

// File: rtl/fwnoc_pkt_size_dec.sv
// Combinational header size decoder shared by the ingress manager and the
// egress arbiter.
module fwnoc_pkt_size_dec
    import fwnoc_pkg::*;
(
    input  logic [SZ_W-1:0]  i_code,
    output logic [PAY_W-1:0] o_count,
    output logic             o_bad
);

    assign o_count = size_decode(i_code);
    assign o_bad   = size_code_bad(i_code);

endmodule

// File: rtl/fwnoc_router_ingress_mgr.sv
// Ingress demultiplexer: decodes the header beat, then steers the whole packet
// to one of four outputs with no buffering and no interleaving.
module fwnoc_router_ingress_mgr
    import fwnoc_pkg::*;
#(
    parameter int DAT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DAT_WIDTH-1:0] i_dat,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic [DAT_WIDTH-1:0] o0_dat,
    output logic [DAT_WIDTH-1:0] o1_dat,
    output logic [DAT_WIDTH-1:0] o2_dat,
    output logic [DAT_WIDTH-1:0] o3_dat,
    output logic                 o0_valid,
    output logic                 o1_valid,
    output logic                 o2_valid,
    output logic                 o3_valid,
    input  logic                 o0_ready,
    input  logic                 o1_ready,
    input  logic                 o2_ready,
    input  logic                 o3_ready,
    output logic                 busy,
    output logic                 err_sz
);

    state_t                 r_state,     w_state_nxt;
    logic [PORT_W-1:0]      r_port,      w_port_nxt;
    logic [PAY_W-1:0]       r_remaining, w_remaining_nxt;
    logic                   r_err_sz,    w_err_sz_nxt;
    logic [PAY_W-1:0]       w_dec_count;
    logic                   w_dec_bad;
    logic [NUM_PORTS-1:0]   w_o_ready;
    logic [NUM_PORTS-1:0]   w_o_valid;

    assign w_o_ready = {o3_ready, o2_ready, o1_ready, o0_ready};

    fwnoc_pkt_size_dec u_size_dec (
        .i_code  (i_dat[SZ_MSB:SZ_LSB]),
        .o_count (w_dec_count),
        .o_bad   (w_dec_bad)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_port      <= '0;
            r_remaining <= '0;
            r_err_sz    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_port      <= w_port_nxt;
            r_remaining <= w_remaining_nxt;
            r_err_sz    <= w_err_sz_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt     = r_state;
        w_port_nxt      = r_port;
        w_remaining_nxt = r_remaining;
        w_err_sz_nxt    = 1'b0;
        w_o_valid       = '0;
        i_ready         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_state_nxt     = ST_FWD;
                    w_port_nxt      = i_dat[PORT_MSB:PORT_LSB];
                    w_remaining_nxt = w_dec_count;
                    w_err_sz_nxt    = w_dec_bad;
                end
            end
            ST_FWD: begin
                w_o_valid[r_port] = i_valid;
                i_ready           = w_o_ready[r_port];
                if (i_valid && w_o_ready[r_port]) begin
                    if (r_remaining == '0) w_state_nxt = ST_IDLE;
                    else                   w_remaining_nxt = r_remaining - PAY_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Data fans out unconditionally; only the selected valid qualifies it.
    assign o0_dat   = i_dat;
    assign o1_dat   = i_dat;
    assign o2_dat   = i_dat;
    assign o3_dat   = i_dat;
    assign o0_valid = w_o_valid[0];
    assign o1_valid = w_o_valid[1];
    assign o2_valid = w_o_valid[2];
    assign o3_valid = w_o_valid[3];
    assign busy     = (r_state == ST_FWD);
    assign err_sz   = r_err_sz;

endmodule

// File: tb/tb_fwnoc_router_ingress_mgr.sv
// Directed bench for fwnoc_router_ingress_mgr: per-port expected-beat queues
// checked every cycle, plus hand-computed latency/length expectations.
module tb_fwnoc_router_ingress_mgr;

    localparam int DW    = 32;
    localparam int LIMIT = 200;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] i_dat;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] o0_dat, o1_dat, o2_dat, o3_dat;
    logic          o0_valid, o1_valid, o2_valid, o3_valid;
    logic          o0_ready, o1_ready, o2_ready, o3_ready;
    logic          busy;
    logic          err_sz;

    fwnoc_router_ingress_mgr #(.DAT_WIDTH(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .i_dat    (i_dat),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .o0_dat   (o0_dat),
        .o1_dat   (o1_dat),
        .o2_dat   (o2_dat),
        .o3_dat   (o3_dat),
        .o0_valid (o0_valid),
        .o1_valid (o1_valid),
        .o2_valid (o2_valid),
        .o3_valid (o3_valid),
        .o0_ready (o0_ready),
        .o1_ready (o1_ready),
        .o2_ready (o2_ready),
        .o3_ready (o3_ready),
        .busy     (busy),
        .err_sz   (err_sz)
    );

    always #5 clock = ~clock;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    int            err_cnt  = 0;
    int            err_cyc  = -1;
    int            pkt_id   = 0;
    logic [DW-1:0] exp_q [4][$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Payload words after the header, straight from the size table.
    function automatic int payload_words(input logic [3:0] code);
        if (code == 4'd0 || code > 4'd5) return 0;
        return 1 << (code - 1);
    endfunction

    task automatic set_ready(input logic r);
        o0_ready = r;
        o1_ready = r;
        o2_ready = r;
        o3_ready = r;
    endtask

    // mode 0: always valid/ready; 1: ready toggles 1,0,..; 2: valid toggles 1,0,..
    task automatic drive(input int mode, input int phase);
        case (mode)
            1:       begin i_valid = 1'b1;            set_ready(phase % 2 == 0); end
            2:       begin i_valid = (phase % 2 == 0); set_ready(1'b1);          end
            default: begin i_valid = 1'b1;            set_ready(1'b1);          end
        endcase
    endtask

    // Every beat presented on o[n] with ready high must be the next expected word.
    always @(negedge clock) begin : compare
        logic [3:0]    v;
        logic [3:0]    rd;
        logic [DW-1:0] d [4];
        if (!reset) begin
            v    = {o3_valid, o2_valid, o1_valid, o0_valid};
            rd   = {o3_ready, o2_ready, o1_ready, o0_ready};
            d[0] = o0_dat; d[1] = o1_dat; d[2] = o2_dat; d[3] = o3_dat;
            check("dat_fanout", (d[0] == i_dat && d[1] == i_dat && d[2] == i_dat && d[3] == i_dat), 1);
            check("valid_onehot", $countones(v) > 1, 0);
            if (!busy) check("idle_quiet", {i_ready, v}, 0);
            for (int n = 0; n < 4; n++) begin
                if (v[n]) begin
                    check($sformatf("o%0d_valid_qual", n), i_valid, 1);
                    check($sformatf("o%0d_i_ready", n), i_ready, rd[n]);
                    if (rd[n]) begin
                        if (exp_q[n].size() == 0)
                            check($sformatf("o%0d_beat_expected", n), 0, 1);
                        else
                            check($sformatf("o%0d_beat", n), d[n], exp_q[n].pop_front());
                    end
                end
            end
            if (err_sz) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    task automatic send_pkt(input logic [DW-1:0] hdr, input int mode, input int abort_at,
                            output int t_present, output int t_first, output int t_last);
        int            npay;
        int            port;
        int            sent;
        int            waits;
        int            phase;
        logic          xfer;
        logic [DW-1:0] words[$];
        npay = payload_words(hdr[3:0]);
        port = int'(hdr[5:4]);
        pkt_id++;
        words.push_back(hdr);
        for (int k = 1; k <= npay; k++) words.push_back(32'hC000_0000 | (pkt_id << 16) | k);
        foreach (words[k]) exp_q[port].push_back(words[k]);
        sent = 0; waits = 0; phase = 0; t_first = -1; t_last = -1;
        t_present = cyc;
        i_dat = words[0];
        drive(mode, phase);
        while (sent < words.size() && waits < LIMIT) begin
            @(negedge clock);
            xfer = i_valid && i_ready;
            if (xfer) begin
                check("busy_during_xfer", busy, 1);
                if (t_first < 0) t_first = cyc;
                t_last = cyc;
            end
            @(posedge clock);
            #1;
            waits++;
            phase++;
            if (xfer) begin
                sent++;
                if (sent < words.size()) i_dat = words[sent];
            end
            if (abort_at > 0 && sent == abort_at) begin
                reset = 1'b1;
                #1;
                check("rst_valids", {o3_valid, o2_valid, o1_valid, o0_valid}, 0);
                check("rst_i_ready", i_ready, 0);
                check("rst_busy", busy, 0);
                exp_q[port].delete();
                i_valid = 1'b0;
                return;
            end
            drive(mode, phase);
        end
        check("pkt_timeout", waits >= LIMIT, 0);
        i_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int tp, tf, tl, tp2, tf2, tl2, e0;
        reset = 1'b1;
        i_valid = 1'b0;
        i_dat = '0;
        set_ready(1'b0);
        repeat (2) @(posedge clock);
        #1;
        check("reset_i_ready", i_ready, 0);
        check("reset_valids", {o3_valid, o2_valid, o1_valid, o0_valid}, 0);
        check("reset_busy", busy, 0);
        check("reset_err_sz", err_sz, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Header-only packet to port 2.
        send_pkt(32'h0000_0020, 0, 0, tp, tf, tl);
        check("t1_latency", tf - tp, 1);
        check("t1_len", tl - tf, 0);
        check("t1_busy_after", busy, 0);
        check("t1_drained", exp_q[2].size(), 0);

        // Size 3 to port 1 with ready toggling: beats at present+2, +4, ..., +10.
        send_pkt(32'h0000_0013, 1, 0, tp, tf, tl);
        check("t2_first", tf - tp, 2);
        check("t2_span", tl - tf, 8);
        check("t2_busy_after", busy, 0);
        check("t2_drained", exp_q[1].size(), 0);

        // Back-to-back: port 0 size 1, then port 3 size 2, one IDLE cycle between.
        send_pkt(32'h0000_0001, 0, 0, tp, tf, tl);
        send_pkt(32'h0000_0032, 0, 0, tp2, tf2, tl2);
        check("t3_a_span", tl - tf, 1);
        check("t3_gap", tf2 - tl, 2);
        check("t3_b_span", tl2 - tf2, 2);
        check("t3_drained", exp_q[0].size() + exp_q[3].size(), 0);

        // Bad size code 7 on port 3: header only, single err pulse.
        e0 = err_cnt;
        send_pkt(32'h0000_0037, 0, 0, tp, tf, tl);
        check("t4_err_pulses", err_cnt - e0, 1);
        check("t4_err_cycle", err_cyc - tp, 1);
        check("t4_len", tl - tf, 0);
        check("t4_drained", exp_q[3].size(), 0);

        // Maximum packet: 17 beats at full rate.
        send_pkt(32'h0000_0005, 0, 0, tp, tf, tl);
        check("t5_latency", tf - tp, 1);
        check("t5_span", tl - tf, 16);
        check("t5_busy_after", busy, 0);
        check("t5_drained", exp_q[0].size(), 0);

        // Source valid dropping every other cycle: size 2 to port 1.
        send_pkt(32'h0000_0012, 2, 0, tp, tf, tl);
        check("t6_first", tf - tp, 2);
        check("t6_span", tl - tf, 4);
        check("t6_drained", exp_q[1].size(), 0);

        // Reset after 2 of 17 beats, then a fresh packet 0x21 to port 2.
        send_pkt(32'h0000_0005, 0, 2, tp, tf, tl);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("t7_idle_after_rst", busy, 0);
        send_pkt(32'h0000_0021, 0, 0, tp, tf, tl);
        check("t7_latency", tf - tp, 1);
        check("t7_span", tl - tf, 1);
        check("t7_drained", exp_q[0].size() + exp_q[2].size(), 0);

        repeat (3) @(posedge clock);
        #1;
        check("err_total", err_cnt, 1);
        check("all_drained", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
